// File: rtl/issue_queue_fifo.sv
// rtl/issue_queue_fifo.sv - in-order issue queue FIFO with flush and error pulses (optional IQ_BYPASS_EN)
module issue_queue_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_front,
    input  logic                     pop_back,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic                     ready,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty_w;
    logic full_w;
    logic bypass_hit;
    logic do_push;
    logic do_pop;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));

`ifdef IQ_BYPASS_EN
    // An entry arriving at an empty queue that is popped in the same cycle
    // flows straight through without touching storage.
    assign bypass_hit = empty_w & push_front & pop_back & ~flush;
`else
    assign bypass_hit = 1'b0;
`endif

    // A same-cycle pop frees the slot, so a push into a full queue is legal then.
    assign do_push = push_front & ~flush & ~bypass_hit & (~full_w | (pop_back & ~empty_w));
    assign do_pop  = pop_back & ~flush & ~empty_w;

    // Next-state for pointers, occupancy and error pulses; flush wins over everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = push_front & full_w & ~pop_back & ~flush;
        unf_d   = pop_back & empty_w & ~flush & ~bypass_hit;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register; storage is deliberately left out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= din;
        end
    end

    // Head entry is presented combinationally; zero when nothing is valid.
    always_comb begin
        dout = '0;
        if (bypass_hit) begin
            dout = din;
        end else if (!empty_w) begin
            dout = mem_q[head_q];
        end
    end

    assign empty         = empty_w;
    assign full          = full_w;
    assign ready         = ~empty_w | bypass_hit;
    assign almost_full   = (count_q >= CNT_W'(AFULL_THRESH));
    assign count         = count_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_issue_queue_fifo.sv
// tb/tb_issue_queue_fifo.sv - scoreboard bench for issue_queue_fifo
module tb_issue_queue_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AFULL = DEPTH - 1;

    logic             clk;
    logic             rst;
    logic             push_front;
    logic             pop_back;
    logic             flush;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             ready;
    logic             almost_full;
    logic [3:0]       count;
    logic             overflow_err;
    logic             underflow_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model[$];

    issue_queue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_front    (push_front),
        .pop_back      (pop_back),
        .flush         (flush),
        .din           (din),
        .dout          (dout),
        .empty         (empty),
        .full          (full),
        .ready         (ready),
        .almost_full   (almost_full),
        .count         (count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic post_state();
        int n;
        n = model.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= AFULL));
        chk("ready", 32'(ready), 32'(n != 0));
        chk("dout", dout, (n == 0) ? 32'h0 : model[0]);
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic p, input logic q, input logic f, input logic [31:0] d);
        int   n;
        logic m_empty, m_full, byp, exp_ovf, exp_unf, dpop, dpush;
        n       = model.size();
        m_empty = (n == 0);
        m_full  = (n == DEPTH);
`ifdef IQ_BYPASS_EN
        byp = m_empty & p & q & ~f;
`else
        byp = 1'b0;
`endif
        exp_ovf = p & m_full & ~q & ~f;
        exp_unf = q & m_empty & ~f & ~byp;
        push_front = p;
        pop_back   = q;
        flush      = f;
        din        = d;
        #1;
        if (byp) begin
            chk("bypass_dout", dout, d);
            chk("bypass_ready", 32'(ready), 32'd1);
        end else if (q && !f && !m_empty) begin
            chk("pop_dout", dout, model[0]);
        end
        dpop  = q & ~f & ~m_empty;
        dpush = p & ~f & ~byp & (~m_full | dpop);
        if (f) begin
            model.delete();
        end else begin
            if (dpop)  void'(model.pop_front());
            if (dpush) model.push_back(d);
        end
        @(posedge clk);
        #1;
        push_front = 1'b0;
        pop_back   = 1'b0;
        flush      = 1'b0;
        din        = '0;
        chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
        chk("underflow_err", 32'(underflow_err), 32'(exp_unf));
        post_state();
    endtask

    initial begin
        rst        = 1'b0;
        push_front = 1'b0;
        pop_back   = 1'b0;
        flush      = 1'b0;
        din        = '0;
        #3;
        chk("rst_overflow_err", 32'(overflow_err), 32'd0);
        chk("rst_underflow_err", 32'(underflow_err), 32'd0);
        post_state();
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
        post_state();

        // Basic ordering
        cycle(1, 0, 0, 32'h11);
        cycle(1, 0, 0, 32'h22);
        cycle(1, 0, 0, 32'h33);
        chk("basic_count3", 32'(count), 32'd3);
        chk("basic_head", dout, 32'h11);
        repeat (3) cycle(0, 1, 0, 32'h0);

        // Fill, then overflow
        for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 0, 32'(i));
        chk("full_after_fill", 32'(full), 32'd1);
        cycle(1, 0, 0, 32'hDEAD);
        chk("overflow_pulse", 32'(overflow_err), 32'd1);
        cycle(0, 0, 0, 32'h0);
        chk("overflow_one_cycle", 32'(overflow_err), 32'd0);

        // Full with simultaneous push and pop
        cycle(1, 1, 0, 32'hAA);
        chk("full_pushpop_count", 32'(count), 32'd8);
        repeat (DEPTH) cycle(0, 1, 0, 32'h0);
        chk("drained_empty", 32'(empty), 32'd1);

        // Flush with concurrent push/pop
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h100 + 32'(i));
        cycle(1, 1, 1, 32'hEE);
        chk("flush_head", 32'(dut.head_q), 32'd0);
        chk("flush_tail", 32'(dut.tail_q), 32'd0);
        cycle(1, 0, 0, 32'h77);
        chk("after_flush_tail", 32'(dut.tail_q), 32'd1);
        cycle(0, 1, 0, 32'h0);

        // Underflow and push+pop on empty
        cycle(0, 1, 0, 32'h0);
        chk("underflow_pulse", 32'(underflow_err), 32'd1);
        cycle(1, 1, 0, 32'h5);
        if (model.size() != 0) cycle(0, 1, 0, 32'h0);

        // Asynchronous reset mid-cycle with 4 entries queued
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 32'h200 + 32'(i));
        #3 rst = 1'b0;
        #1;
        model.delete();
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_dout", dout, 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        post_state();
        cycle(1, 0, 0, 32'h300);
        cycle(1, 0, 0, 32'h301);
        cycle(0, 1, 0, 32'h0);
        cycle(0, 1, 0, 32'h0);

        // Random traffic across many wraps
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0), $urandom);
        end
        while (model.size() != 0) cycle(0, 1, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
